// File: rtl/program_sequencer_ctrl.sv
// program_sequencer_ctrl: program counter with RUN/HALT/STEP run-control, breakpoint and execute counter
// Ports: clk, sync_reset (sync, active-high); jmp/jmp_nz/dont_jmp/ir_nibble decoded jump controls;
//        halt_req/run_req/step_req run-control levels; bp_en/bp_addr breakpoint;
//        pm_addr program address, exec_en execute qualify, halted, step_ack, bp_hit, state,
//        instr_count executed-instruction count, from_PS debug copy of pc.
module program_sequencer_ctrl #(
    parameter int PC_WIDTH     = 8,
    parameter int CNT_WIDTH    = 16,
    parameter bit START_HALTED = 1'b0
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 jmp,
    input  logic                 jmp_nz,
    input  logic                 dont_jmp,
    input  logic [3:0]           ir_nibble,
    input  logic                 halt_req,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    output logic [PC_WIDTH-1:0]  pm_addr,
    output logic                 exec_en,
    output logic                 halted,
    output logic                 step_ack,
    output logic                 bp_hit,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [7:0]           from_PS
);
    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, STEP = 2'd2} state_t;
    state_t               st;
    logic [PC_WIDTH-1:0]  pc;
    logic                 resume;
    logic [7:0]           tgt8;
    logic                 bp_now;
    logic                 take;
    assign tgt8        = {ir_nibble, 4'h0};
    assign exec_en     = ~sync_reset & (st == RUN | st == STEP);
    // resume masks the breakpoint for the first RUN cycle so a resumed halt executes its instruction
    assign bp_now      = st == RUN & bp_en & pc == bp_addr & ~resume;
    assign take        = exec_en & (jmp | (jmp_nz & ~dont_jmp));
    assign pm_addr     = pc;
    assign from_PS     = 8'(pc);
    assign halted      = st == HALT;
    assign step_ack    = ~sync_reset & st == STEP;
    assign state       = st;
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc          <= '0;
            instr_count <= '0;
            bp_hit      <= 1'b0;
            resume      <= 1'b1;
            st          <= START_HALTED ? HALT : RUN;
        end else begin
            pc     <= take ? tgt8[PC_WIDTH-1:0] : (st == HALT | bp_now) ? pc : pc + 1'b1;
            resume <= st != RUN;
            if (exec_en & ~&instr_count)
                instr_count <= instr_count + 1'b1;
            case (st)
                RUN: begin
                    if (halt_req | bp_now) st <= HALT;
                    if (bp_now) bp_hit <= 1'b1;
                end
                HALT: begin
                    if (run_req) begin
                        st     <= RUN;
                        bp_hit <= 1'b0;
                    end else if (step_req) begin
                        st     <= STEP;
                        bp_hit <= 1'b0;
                    end
                end
                default: st <= HALT;
            endcase
        end
    end
endmodule
